// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-master memory arbiter: FSM state values,
// one-hot grant codes and a small decode helper.
package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_RESP  = ST_RESP
  } state_t;

  // An all-zero byte mask marks a read; any other pattern is a write.
  function automatic logic is_read(input logic [3:0] wstrb);
    return (wstrb == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// picorv32-style valid/ready memory request bundle; one instance per master.
interface mem_bus_if #(
  parameter int ADDR_W = 32
);
  import mem_bus_pkg::*;

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              ready;
  logic [31:0]       rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to whichever master did not win last time.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GRANT_NONE;
    if (req == 2'b11) begin
      gnt = (last_grant == GRANT_M0) ? GRANT_M1 : GRANT_M0;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous memory between the CPU (M0) and the
// loader/debug port (M1): one strobed access per transaction, 3-cycle cadence.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_if.slave          m0,
  mem_bus_if.slave          m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        grant,
  output logic              err_oob
);

  // Compared one bit wider than the address so a large limit cannot wrap.
  localparam logic [ADDR_W:0] OOB_LIMIT = (ADDR_W+1)'(MEM_WORDS) << 2;

  state_t            state_q;
  logic [1:0]        last_grant_q;
  logic [1:0]        grant_q;
  logic [3:0]        wstrb_q;
  logic              oob_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wmask_q;
  logic              mem_rstrb_q;
  logic [1:0]        ready_q;
  logic              rd_q;
  logic              err_q;

  logic [1:0]        gnt_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [31:0]       sel_wdata_d;
  logic [3:0]        sel_wstrb_d;
  logic              oob_d;

  rr_arb2 u_rr_arb2 (
    .req        ({m1.valid, m0.valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt_d)
  );

  always_comb begin
    sel_addr_d  = m0.addr;
    sel_wdata_d = m0.wdata;
    sel_wstrb_d = m0.wstrb;
    if (gnt_d[1]) begin
      sel_addr_d  = m1.addr;
      sel_wdata_d = m1.wdata;
      sel_wstrb_d = m1.wstrb;
    end
    oob_d = ({1'b0, sel_addr_d} >= OOB_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_M1;
      grant_q      <= GRANT_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= 4'b0000;
      mem_rstrb_q  <= 1'b0;
      ready_q      <= 2'b00;
      rd_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
      mem_rstrb_q <= 1'b0;
      ready_q     <= 2'b00;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (gnt_d != GRANT_NONE) begin
            // Payload is captured here, so later changes by the master are ignored.
            grant_q      <= gnt_d;
            last_grant_q <= gnt_d;
            wstrb_q      <= sel_wstrb_d;
            oob_q        <= oob_d;
            mem_addr_q   <= sel_addr_d;
            mem_wdata_q  <= sel_wdata_d;
            mem_wmask_q  <= oob_d ? 4'b0000 : sel_wstrb_d;
            mem_rstrb_q  <= !oob_d && is_read(sel_wstrb_d);
            state_q      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          ready_q <= grant_q;
          rd_q    <= !oob_q && is_read(wstrb_q);
          err_q   <= oob_q;
          state_q <= S_RESP;
        end

        S_RESP: begin
          grant_q <= GRANT_NONE;
          state_q <= S_IDLE;
        end

        default: begin
          grant_q <= GRANT_NONE;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_rstrb = mem_rstrb_q;
  assign grant     = grant_q;
  assign err_oob   = err_q;

  // Memory read data arrives the cycle after the strobe, i.e. in RESP.
  assign m0.ready = ready_q[0];
  assign m1.ready = ready_q[1];
  assign m0.rdata = (ready_q[0] && rd_q) ? mem_rdata : 32'h0;
  assign m1.rdata = (ready_q[1] && rd_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed transaction table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int NCYC = 600;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [1:0]  grant;
  logic        err_oob;
  logic        init_mem;

  int n_checks = 0;
  int n_err    = 0;

  mem_bus_if #(.ADDR_W(32)) m0_if ();
  mem_bus_if #(.ADDR_W(32)) m1_if ();

  mem_bus_arbiter #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .grant     (grant),
    .err_oob   (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'h12345678;
    return 32'(i) * 32'h00010001;
  endfunction

  // Synchronous memory: registered read on strobe, byte-masked write.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s;
    end else begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from IDLE, checked through issue, response and idle.
  task automatic do_txn(input string nm, input int m, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic e_rstrb,
                        input logic [3:0] e_wmask, input logic [31:0] e_rdata, input logic e_err);
    logic [1:0] g;
    g = (m == 0) ? 2'b01 : 2'b10;
    drive(m, 1'b1, a, d, s);
    step();
    chk({nm, "_issue_grant"}, 32'(grant), 32'(g));
    chk({nm, "_issue_rstrb"}, 32'(mem_rstrb), 32'(e_rstrb));
    chk({nm, "_issue_wmask"}, 32'(mem_wmask), 32'(e_wmask));
    chk({nm, "_issue_addr"}, mem_addr, a);
    chk({nm, "_issue_ready"}, 32'({m1_if.ready, m0_if.ready}), 32'h0);
    step();
    chk({nm, "_resp_ready"}, 32'({m1_if.ready, m0_if.ready}), 32'(g));
    chk({nm, "_resp_rdata"}, (m == 0) ? m0_if.rdata : m1_if.rdata, e_rdata);
    chk({nm, "_resp_other_rdata"}, (m == 0) ? m1_if.rdata : m0_if.rdata, 32'h0);
    chk({nm, "_resp_err"}, 32'(err_oob), 32'(e_err));
    chk({nm, "_resp_strobes"}, 32'({mem_rstrb, mem_wmask}), 32'h0);
    drive(m, 1'b0, a, d, s);
    step();
    chk({nm, "_idle_grant"}, 32'(grant), 32'h0);
    chk({nm, "_idle_ready"}, 32'({m1_if.ready, m0_if.ready}), 32'h0);
  endtask

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        e_rstrb;
    logic [3:0]  e_wmask;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [0:10];

  logic [1:0]  e_grant [0:NCYC+2];
  logic        e_issue [0:NCYC+2];
  logic [31:0] e_addr  [0:NCYC+2];
  logic [31:0] e_wdata [0:NCYC+2];
  logic [3:0]  e_wmask [0:NCYC+2];
  logic        e_rstrb [0:NCYC+2];
  logic [1:0]  e_ready [0:NCYC+2];
  logic [31:0] e_rd0   [0:NCYC+2];
  logic [31:0] e_rd1   [0:NCYC+2];
  logic        e_err   [0:NCYC+2];
  logic [31:0] shadow  [0:1023];

  initial begin
    int          pend [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [3:0]  ps [2];
    int          free_at;
    int          last_w;
    int          w;
    int          rdy_cnt [2];
    logic [1:0]  eg;

    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    reset    = 1'b1;
    init_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    init_mem = 1'b0;

    // Reset state: everything quiet for several idle cycles.
    for (int c = 0; c < 3; c++) begin
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
      chk("rst_rdata0", m0_if.rdata, 32'h0);
      chk("rst_rdata1", m1_if.rdata, 32'h0);
      chk("rst_wmask", 32'(mem_wmask), 32'h0);
      chk("rst_rstrb", 32'(mem_rstrb), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_err", 32'(err_oob), 32'h0);
      step();
    end

    vecs[0]  = '{0, 32'h0000_0010, 32'h0,         4'b0000, 1'b1, 4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1, 32'h0000_0020, 32'hA5A5A5A5,  4'b0011, 1'b0, 4'b0011, 32'h0,        1'b0};
    vecs[2]  = '{1, 32'h0000_0020, 32'h0,         4'b0000, 1'b1, 4'b0000, 32'h1234A5A5, 1'b0};
    vecs[3]  = '{0, 32'h0000_1000, 32'h0,         4'b0000, 1'b0, 4'b0000, 32'h0,        1'b1};
    vecs[4]  = '{0, 32'h0000_0FFC, 32'hCAFEF00D,  4'b1111, 1'b0, 4'b1111, 32'h0,        1'b0};
    vecs[5]  = '{1, 32'h0000_0FFC, 32'h0,         4'b0000, 1'b1, 4'b0000, 32'hCAFEF00D, 1'b0};
    vecs[6]  = '{1, 32'hFFFF_FFFC, 32'h11111111,  4'b1111, 1'b0, 4'b0000, 32'h0,        1'b1};
    vecs[7]  = '{0, 32'h0000_0044, 32'h00AB0000,  4'b0100, 1'b0, 4'b0100, 32'h0,        1'b0};
    vecs[8]  = '{0, 32'h0000_0044, 32'h0,         4'b0000, 1'b1, 4'b0000, 32'h00AB0011, 1'b0};
    vecs[9]  = '{1, 32'h0000_1000, 32'h22222222,  4'b1000, 1'b0, 4'b0000, 32'h0,        1'b1};
    vecs[10] = '{0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 1'b0, 4'b0000, 32'h0,        1'b1};

    for (int i = 0; i < 11; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].e_rstrb, vecs[i].e_wmask, vecs[i].e_rdata, vecs[i].e_err);

    // Both masters hold valid for 12 cycles straight after reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h20, 32'h0, 4'h0);
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    for (int c = 0; c < 12; c++) begin
      if (c % 3 == 0) eg = 2'b00;
      else eg = (((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("tie_grant@%0d", c), 32'(grant), 32'(eg));
      if (m0_if.ready) rdy_cnt[0]++;
      if (m1_if.ready) rdy_cnt[1]++;
      step();
    end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("tie_ready_m0", 32'(rdy_cnt[0]), 32'd2);
    chk("tie_ready_m1", 32'(rdy_cnt[1]), 32'd2);
    step();
    chk("tie_end_grant", 32'(grant), 32'h0);

    // Reset lands while a write is in ISSUE; the write must still commit.
    drive(0, 1'b1, 32'h40, 32'h13579BDF, 4'b1111);
    step();
    chk("rstmid_issue_wmask", 32'(mem_wmask), 32'hF);
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    chk("rstmid_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
    chk("rstmid_grant", 32'(grant), 32'h0);
    chk("rstmid_strobes", 32'({mem_rstrb, mem_wmask}), 32'h0);
    reset = 1'b0;
    step();
    do_txn("rstmid_readback", 0, 32'h40, 32'h0, 4'b0000, 1'b1, 4'b0000, 32'h13579BDF, 1'b0);

    // Randomized traffic against a transaction-level model.
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    for (int k = 0; k <= NCYC + 2; k++) begin
      e_grant[k] = 2'b00; e_issue[k] = 1'b0; e_addr[k] = 32'h0; e_wdata[k] = 32'h0;
      e_wmask[k] = 4'h0; e_rstrb[k] = 1'b0; e_ready[k] = 2'b00;
      e_rd0[k] = 32'h0; e_rd1[k] = 32'h0; e_err[k] = 1'b0;
    end
    pend[0] = 0; pend[1] = 0;
    free_at = 0;
    last_w  = 1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      chk($sformatf("rnd_grant@%0d", k), 32'(grant), 32'(e_grant[k]));
      chk($sformatf("rnd_rstrb@%0d", k), 32'(mem_rstrb), 32'(e_rstrb[k]));
      chk($sformatf("rnd_wmask@%0d", k), 32'(mem_wmask), 32'(e_wmask[k]));
      chk($sformatf("rnd_ready@%0d", k), 32'({m1_if.ready, m0_if.ready}), 32'(e_ready[k]));
      chk($sformatf("rnd_rdata0@%0d", k), m0_if.rdata, e_rd0[k]);
      chk($sformatf("rnd_rdata1@%0d", k), m1_if.rdata, e_rd1[k]);
      chk($sformatf("rnd_err@%0d", k), 32'(err_oob), 32'(e_err[k]));
      if (e_issue[k]) begin
        chk($sformatf("rnd_addr@%0d", k), mem_addr, e_addr[k]);
        chk($sformatf("rnd_wdata@%0d", k), mem_wdata, e_wdata[k]);
      end

      for (int m = 0; m < 2; m++) begin
        logic rdy;
        logic done;
        rdy  = (m == 0) ? m0_if.ready : m1_if.ready;
        done = 1'b0;
        if (pend[m] != 0 && rdy) begin
          pend[m] = 0;
          done = 1'b1;
        end
        if (pend[m] == 0 && !done && k < NCYC - 12 && $urandom_range(0, 99) < 55) begin
          if ($urandom_range(0, 9) == 0)
            pa[m] = ($urandom_range(0, 1) == 0) ? 32'h1000 + 4 * $urandom_range(0, 15)
                                                 : 32'hFFFF_FFFC - 4 * $urandom_range(0, 15);
          else
            pa[m] = 32'h800 + 4 * $urandom_range(0, 63);
          pd[m] = $urandom;
          ps[m] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
          pend[m] = 1;
        end
        drive(m, pend[m] != 0, pa[m], pd[m], ps[m]);
      end

      if (k >= free_at) begin
        w = -1;
        if (pend[0] != 0 && pend[1] != 0) w = (last_w == 0) ? 1 : 0;
        else if (pend[0] != 0) w = 0;
        else if (pend[1] != 0) w = 1;
        if (w >= 0) begin
          logic oob;
          logic rd;
          int   idx;
          oob = ({1'b0, pa[w]} >= 33'd4096);
          rd  = (ps[w] == 4'b0000);
          idx = int'(pa[w][11:2]);
          e_grant[k+1] = (w == 0) ? 2'b01 : 2'b10;
          e_grant[k+2] = e_grant[k+1];
          e_issue[k+1] = 1'b1;
          e_addr[k+1]  = pa[w];
          e_wdata[k+1] = pd[w];
          e_wmask[k+1] = oob ? 4'b0000 : ps[w];
          e_rstrb[k+1] = !oob && rd;
          e_ready[k+2] = e_grant[k+1];
          if (!oob && rd) begin
            if (w == 0) e_rd0[k+2] = shadow[idx];
            else        e_rd1[k+2] = shadow[idx];
          end
          e_err[k+2] = oob;
          if (!oob && !rd)
            for (int b = 0; b < 4; b++)
              if (ps[w][b]) shadow[idx][8*b +: 8] = pd[w][8*b +: 8];
          last_w  = w;
          free_at = k + 3;
        end
      end
      step();
    end
    chk("rnd_all_served_m0", 32'(pend[0]), 32'h0);
    chk("rnd_all_served_m1", 32'(pend[1]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
